// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage sitting upstream of the hazard
// detection unit (HDU) and decode.
//
// It owns three things:
//   - the PC register,
//   - the instruction-memory request handshake,
//   - the IF/ID pipeline register.
//
// Ports:
//   clock, reset_n          rising-edge clock, async active-low reset
//   pc_wr_in, if_id_wr_in   HDU write enables (0 = stall)
//   branch_taken_in         one-cycle redirect pulse
//   branch_target_in        redirect address, used unmodified
//   imem_req_out            memory request (high whenever out of reset)
//   imem_addr_out           fetch address (the PC register)
//   imem_data_in            instruction word, valid with imem_ready_in
//   imem_ready_in           memory completes the request this cycle
//   if_id_instruction_out   IF/ID instruction
//   if_id_pc4_out           IF/ID PC+4
//   if_id_valid_out         IF/ID holds a real instruction (0 = bubble)
//   instruction2msb_out     upper 16 bits of the IF/ID instruction (for the HDU)
//   fetch_stall_out         fetch is not completing this cycle
module fetch_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  pc_wr_in,
  input  logic                  if_id_wr_in,
  input  logic                  branch_taken_in,
  input  logic [DATA_WIDTH-1:0] branch_target_in,
  output logic                  imem_req_out,
  output logic [DATA_WIDTH-1:0] imem_addr_out,
  input  logic [DATA_WIDTH-1:0] imem_data_in,
  input  logic                  imem_ready_in,
  output logic [DATA_WIDTH-1:0] if_id_instruction_out,
  output logic [DATA_WIDTH-1:0] if_id_pc4_out,
  output logic                  if_id_valid_out,
  output logic [15:0]           instruction2msb_out,
  output logic                  fetch_stall_out
);

  localparam logic [DATA_WIDTH-1:0] PC_INC = DATA_WIDTH'(32'd4);
  localparam logic [DATA_WIDTH-1:0] ZERO_W = '0;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_WAIT   = 2'd1,
    ST_SQUASH = 2'd2
  } state_t;

  state_t                state_r;
  state_t                state_nxt_s;
  logic [DATA_WIDTH-1:0] pc_r;
  logic [DATA_WIDTH-1:0] pc_nxt_s;
  logic [DATA_WIDTH-1:0] target_r;
  logic [DATA_WIDTH-1:0] target_nxt_s;
  logic [DATA_WIDTH-1:0] ifid_instr_r;
  logic [DATA_WIDTH-1:0] ifid_instr_nxt_s;
  logic [DATA_WIDTH-1:0] ifid_pc4_r;
  logic [DATA_WIDTH-1:0] ifid_pc4_nxt_s;
  logic                  ifid_valid_r;
  logic                  ifid_valid_nxt_s;
  logic                  stall_s;
  logic                  advance_s;
  logic                  bubble_s;
  logic [DATA_WIDTH-1:0] pc4_s;
  logic [DATA_WIDTH-1:0] squash_target_s;

  assign stall_s = !pc_wr_in || !if_id_wr_in;

  // PC+4 wraps modulo 2^DATA_WIDTH.
  assign pc4_s = pc_r + PC_INC;

  // In SQUASH, a branch arriving this cycle overrides the latched target.
  assign squash_target_s = branch_taken_in ? branch_target_in : target_r;

  // The request drops with reset_n itself, so an in-flight fetch is
  // abandoned immediately, without waiting for a clock edge.
  assign imem_req_out          = reset_n;
  assign imem_addr_out         = pc_r;
  assign fetch_stall_out       = (state_r != ST_FETCH) || !imem_ready_in;
  assign if_id_instruction_out = ifid_instr_r;
  assign if_id_pc4_out         = ifid_pc4_r;
  assign if_id_valid_out       = ifid_valid_r;
  assign instruction2msb_out   = ifid_instr_r[DATA_WIDTH-1 -: 16];

  // Next-state, PC, redirect latch and IF/ID update decisions.
  always_comb begin
    state_nxt_s  = state_r;
    pc_nxt_s     = pc_r;
    target_nxt_s = target_r;
    advance_s    = 1'b0;
    bubble_s     = 1'b0;
    case (state_r)
      ST_FETCH: begin
        if (imem_ready_in) begin
          if (branch_taken_in) begin
            // Flush takes priority over a stall.
            pc_nxt_s = branch_target_in;
            bubble_s = 1'b1;
          end else if (stall_s) begin
            // Data discarded; the same address is fetched again.
            bubble_s = 1'b0;
          end else begin
            pc_nxt_s  = pc4_s;
            advance_s = 1'b1;
          end
        end else begin
          if (branch_taken_in) begin
            // The address must stay put until the pending request
            // completes, so the redirect is parked in the latch.
            target_nxt_s = branch_target_in;
            state_nxt_s  = ST_SQUASH;
            bubble_s     = 1'b1;
          end else begin
            state_nxt_s = ST_WAIT;
            bubble_s    = !stall_s;
          end
        end
      end
      ST_WAIT: begin
        if (branch_taken_in) begin
          target_nxt_s = branch_target_in;
          state_nxt_s  = ST_SQUASH;
          bubble_s     = 1'b1;
        end else if (imem_ready_in) begin
          state_nxt_s = ST_FETCH;
          if (stall_s) begin
            bubble_s = 1'b0;
          end else begin
            pc_nxt_s  = pc4_s;
            advance_s = 1'b1;
          end
        end else begin
          bubble_s = !stall_s;
        end
      end
      ST_SQUASH: begin
        target_nxt_s = squash_target_s;
        bubble_s     = !stall_s;
        if (imem_ready_in) begin
          pc_nxt_s    = squash_target_s;
          state_nxt_s = ST_FETCH;
        end else begin
          pc_nxt_s = pc_r;
        end
      end
      default: begin
        state_nxt_s = ST_FETCH;
        pc_nxt_s    = RESET_PC;
        bubble_s    = 1'b1;
      end
    endcase

    if (advance_s) begin
      ifid_instr_nxt_s = imem_data_in;
      ifid_pc4_nxt_s   = pc4_s;
      ifid_valid_nxt_s = 1'b1;
    end else if (bubble_s) begin
      ifid_instr_nxt_s = ZERO_W;
      ifid_pc4_nxt_s   = ZERO_W;
      ifid_valid_nxt_s = 1'b0;
    end else begin
      ifid_instr_nxt_s = ifid_instr_r;
      ifid_pc4_nxt_s   = ifid_pc4_r;
      ifid_valid_nxt_s = ifid_valid_r;
    end
  end

  // State, PC, redirect latch and IF/ID register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_FETCH;
      pc_r         <= RESET_PC;
      target_r     <= ZERO_W;
      ifid_instr_r <= ZERO_W;
      ifid_pc4_r   <= ZERO_W;
      ifid_valid_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      pc_r         <= pc_nxt_s;
      target_r     <= target_nxt_s;
      ifid_instr_r <= ifid_instr_nxt_s;
      ifid_pc4_r   <= ifid_pc4_nxt_s;
      ifid_valid_r <= ifid_valid_nxt_s;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage.
//
// Two instances share the stimulus:
//   - u_dut  uses RESET_PC = 0,
//   - u_dut2 uses RESET_PC = 32'hFFFF_FFFC, to observe the PC wrap after reset.
//
// Instruction memory is a combinational function of the address.
module tb_fetch_stage;

  logic        clock;
  logic        reset_n;
  logic        pc_wr_in;
  logic        if_id_wr_in;
  logic        branch_taken_in;
  logic [31:0] branch_target_in;
  logic        imem_ready_in;

  logic        imem_req_out,  imem_req2;
  logic [31:0] imem_addr_out, imem_addr2;
  logic [31:0] imem_data_in,  imem_data2;
  logic [31:0] if_id_instruction_out, instr2;
  logic [31:0] if_id_pc4_out, pc4_2;
  logic        if_id_valid_out, valid2;
  logic [15:0] instruction2msb_out, msb2;
  logic        fetch_stall_out, stall2;

  int n_tests = 0;
  int n_fail  = 0;

  // Memory contents: distinct, nonzero word per address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[15:0] ^ 16'h1F2E, a[15:0] ^ 16'hC3C3};
    return w;
  endfunction

  function automatic logic [31:0] msb_of(input logic [31:0] a);
    logic [31:0] w;
    w = mem_word(a);
    return {16'h0000, w[31:16]};
  endfunction

  assign imem_data_in = mem_word(imem_addr_out);
  assign imem_data2   = mem_word(imem_addr2);

  fetch_stage #(.DATA_WIDTH(32), .RESET_PC(32'h0000_0000)) u_dut (
    .clock                 (clock),
    .reset_n               (reset_n),
    .pc_wr_in              (pc_wr_in),
    .if_id_wr_in           (if_id_wr_in),
    .branch_taken_in       (branch_taken_in),
    .branch_target_in      (branch_target_in),
    .imem_req_out          (imem_req_out),
    .imem_addr_out         (imem_addr_out),
    .imem_data_in          (imem_data_in),
    .imem_ready_in         (imem_ready_in),
    .if_id_instruction_out (if_id_instruction_out),
    .if_id_pc4_out         (if_id_pc4_out),
    .if_id_valid_out       (if_id_valid_out),
    .instruction2msb_out   (instruction2msb_out),
    .fetch_stall_out       (fetch_stall_out)
  );

  fetch_stage #(.DATA_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) u_dut2 (
    .clock                 (clock),
    .reset_n               (reset_n),
    .pc_wr_in              (pc_wr_in),
    .if_id_wr_in           (if_id_wr_in),
    .branch_taken_in       (branch_taken_in),
    .branch_target_in      (branch_target_in),
    .imem_req_out          (imem_req2),
    .imem_addr_out         (imem_addr2),
    .imem_data_in          (imem_data2),
    .imem_ready_in         (imem_ready_in),
    .if_id_instruction_out (instr2),
    .if_id_pc4_out         (pc4_2),
    .if_id_valid_out       (valid2),
    .instruction2msb_out   (msb2),
    .fetch_stall_out       (stall2)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Check the IF/ID register against an expected fetch (or a bubble).
  task automatic check_ifid(input string tag, input logic vld, input logic [31:0] a);
    if (vld) begin
      check({tag, ".instr"}, if_id_instruction_out, mem_word(a));
      check({tag, ".pc4"},   if_id_pc4_out, a + 32'd4);
      check({tag, ".valid"}, {31'd0, if_id_valid_out}, 32'd1);
    end else begin
      check({tag, ".valid"}, {31'd0, if_id_valid_out}, 32'd0);
      check({tag, ".instr"}, if_id_instruction_out, 32'd0);
    end
  endtask

  initial begin
    reset_n          = 1'b0;
    pc_wr_in         = 1'b1;
    if_id_wr_in      = 1'b1;
    branch_taken_in  = 1'b0;
    branch_target_in = 32'd0;
    imem_ready_in    = 1'b1;

    // ---------------- Reset state ----------------
    cyc(); cyc();
    check("rst.req",   {31'd0, imem_req_out}, 32'd0);
    check("rst.addr",  imem_addr_out, 32'd0);
    check("rst.valid", {31'd0, if_id_valid_out}, 32'd0);
    check("rst.pc4",   if_id_pc4_out, 32'd0);
    reset_n = 1'b1;
    #1;

    // ---------------- Sequential fetch ----------------
    check("c0.req",   {31'd0, imem_req_out}, 32'd1);
    check("c0.addr",  imem_addr_out, 32'd0);
    check("c0.stall", {31'd0, fetch_stall_out}, 32'd0);

    cyc();
    check("c1.addr", imem_addr_out, 32'd4);
    check_ifid("c1", 1'b1, 32'd0);
    check("c1.msb",   {16'h0000, instruction2msb_out}, msb_of(32'd0));
    check("c1.stall", {31'd0, fetch_stall_out}, 32'd0);

    cyc();
    check("c2.addr", imem_addr_out, 32'd8);
    check_ifid("c2", 1'b1, 32'd4);

    // ---------------- HDU stall for one cycle at addr 8 ----------------
    pc_wr_in    = 1'b0;
    if_id_wr_in = 1'b0;
    cyc();
    pc_wr_in    = 1'b1;
    if_id_wr_in = 1'b1;
    check("stall.addr", imem_addr_out, 32'd8);
    check_ifid("stall", 1'b1, 32'd4);

    cyc();
    check("c4.addr", imem_addr_out, 32'd12);
    check_ifid("c4", 1'b1, 32'd8);

    // ---------------- Branch at addr 12 to 0x40 ----------------
    branch_taken_in  = 1'b1;
    branch_target_in = 32'h40;
    cyc();
    branch_taken_in = 1'b0;
    check("br.addr", imem_addr_out, 32'h40);
    check_ifid("br", 1'b0, 32'd0);
    check("br.pc4", if_id_pc4_out, 32'd0);

    cyc();
    check("br1.addr", imem_addr_out, 32'h44);
    check_ifid("br1", 1'b1, 32'h40);

    // Redirect to 16 to set up the wait-state test.
    branch_taken_in  = 1'b1;
    branch_target_in = 32'd16;
    cyc();
    branch_taken_in = 1'b0;
    check("to16.addr", imem_addr_out, 32'd16);

    // ---------------- Three wait cycles at addr 16 ----------------
    imem_ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("wait%0d.addr", i),  imem_addr_out, 32'd16);
      check($sformatf("wait%0d.stall", i), {31'd0, fetch_stall_out}, 32'd1);
      cyc();
      check($sformatf("wait%0d.valid", i), {31'd0, if_id_valid_out}, 32'd0);
    end
    imem_ready_in = 1'b1;
    #1;
    // Still in WAIT, so the stall flag stays up on the completing cycle.
    check("wrdy.stall", {31'd0, fetch_stall_out}, 32'd1);
    cyc();
    check("wdone.addr", imem_addr_out, 32'd20);
    check_ifid("wdone", 1'b1, 32'd16);
    check("wdone.stall", {31'd0, fetch_stall_out}, 32'd0);

    cyc();
    check("c12.addr", imem_addr_out, 32'd24);
    check_ifid("c12", 1'b1, 32'd20);

    // ---------------- WAIT at 24, branch 0x80, then 0xC0 in SQUASH ----------------
    imem_ready_in = 1'b0;
    cyc();
    branch_taken_in  = 1'b1;
    branch_target_in = 32'h80;
    #1;
    check("sq0.addr", imem_addr_out, 32'd24);
    cyc();
    branch_target_in = 32'hC0;
    #1;
    check("sq1.addr",  imem_addr_out, 32'd24);
    check("sq1.valid", {31'd0, if_id_valid_out}, 32'd0);
    cyc();
    branch_taken_in = 1'b0;
    imem_ready_in   = 1'b1;
    #1;
    check("sq2.addr",  imem_addr_out, 32'd24);
    check("sq2.stall", {31'd0, fetch_stall_out}, 32'd1);
    cyc();
    check("sq3.addr", imem_addr_out, 32'hC0);
    check_ifid("sq3", 1'b0, 32'd0);
    cyc();
    check("sq4.addr", imem_addr_out, 32'hC4);
    check_ifid("sq4", 1'b1, 32'hC0);

    // ---------------- Async reset mid-WAIT ----------------
    imem_ready_in = 1'b0;
    cyc();
    check("w2.addr", imem_addr_out, 32'hC4);
    #2;
    reset_n = 1'b0;
    #1;
    check("ar.req",   {31'd0, imem_req_out}, 32'd0);
    check("ar.valid", {31'd0, if_id_valid_out}, 32'd0);
    check("ar.instr", if_id_instruction_out, 32'd0);
    check("ar.msb",   {16'h0000, instruction2msb_out}, 32'd0);
    check("ar.addr",  imem_addr_out, 32'd0);
    check("ar.addr2", imem_addr2, 32'hFFFF_FFFC);

    cyc();
    reset_n       = 1'b1;
    imem_ready_in = 1'b1;
    #1;
    check("rs0.req",   {31'd0, imem_req_out}, 32'd1);
    check("rs0.addr",  imem_addr_out, 32'd0);
    check("rs0.addr2", imem_addr2, 32'hFFFF_FFFC);
    cyc();
    check("rs1.addr",   imem_addr_out, 32'd4);
    check("rs1.addr2",  imem_addr2, 32'd0);
    check("rs1.pc4_2",  pc4_2, 32'd0);
    check("rs1.instr2", instr2, mem_word(32'hFFFF_FFFC));
    check("rs1.valid2", {31'd0, valid2}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
